// File: rtl/elevator_call_latch_pkg.sv
// Request channel map shared with the elevator FSM, so clr and req wiring agree on bit indices.
package elevator_pkg;

    localparam int NUM_REQ = 7;

    localparam int REQ_F1UP = 0;
    localparam int REQ_F2DN = 1;
    localparam int REQ_F2UP = 2;
    localparam int REQ_F3DN = 3;
    localparam int REQ_CAR1 = 4;
    localparam int REQ_CAR2 = 5;
    localparam int REQ_CAR3 = 6;

    typedef logic [NUM_REQ-1:0] req_vec_t;

    function automatic logic [2:0] req_count(input req_vec_t v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < NUM_REQ; i++) n = n + 3'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/elevator_call_latch_if.sv
// Button/clear inputs and latched request outputs of the call latch.
interface elevator_call_latch_if;
    import elevator_pkg::*;

    req_vec_t   btn_raw;
    req_vec_t   clr;
    req_vec_t   req;
    logic       req_any;
    logic [2:0] req_cnt;

    modport master (output btn_raw, clr, input req, req_any, req_cnt);
    modport slave  (input btn_raw, clr, output req, req_any, req_cnt);

endinterface

// File: rtl/elevator_call_latch_debounce.sv
// One button channel: 2-flop synchroniser, plus a stability filter when CALL_DEBOUNCE_EN is defined.
module call_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic lvl
);

    if (DEBOUNCE_CYCLES < 2) begin : g_cfg_check
        $error("DEBOUNCE_CYCLES must be at least 2");
    end

    logic [1:0] sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= '0;
        else        sync <= {sync[0], btn_raw};
    end

`ifdef CALL_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic             stable;

    // Any agreement restarts the count, so only an unbroken run of the new level is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (sync[1] == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            stable <= sync[1];
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign lvl = stable;
`else
    assign lvl = sync[1];
`endif

endmodule

// File: rtl/elevator_call_latch.sv
// Sticky hall/car call latch: per-channel edge detect, clear-priority latch and request popcount.
module elevator_call_latch
    import elevator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    elevator_call_latch_if.slave  bus
);

    req_vec_t lvl;
    req_vec_t lvl_d;
    req_vec_t rise;
    req_vec_t req;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_chan
        call_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_deb (
            .clk     (clk),
            .rst_n   (rst_n),
            .btn_raw (bus.btn_raw[i]),
            .lvl     (lvl[i])
        );
    end

    assign rise = lvl & ~lvl_d;

    // Clear wins over a same-cycle rise; a held button cannot re-latch because only edges set req.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_d <= '0;
            req   <= '0;
        end else begin
            lvl_d <= lvl;
            req   <= (req | rise) & ~bus.clr;
        end
    end

    assign bus.req     = req;
    assign bus.req_any = |req;
    assign bus.req_cnt = req_count(req);

endmodule

// File: tb/tb_elevator_call_latch.sv
// Self-checking bench for elevator_call_latch; build with CALL_DEBOUNCE_EN to exercise the filter.
module tb_elevator_call_latch;

    localparam int DEB = 16;
`ifdef CALL_DEBOUNCE_EN
    localparam int LAT = DEB + 2;
`else
    localparam int LAT = 2;
`endif

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    elevator_call_latch_if bus ();

    elevator_call_latch #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: a contact change is seen two edges after it is sampled; a request is set on
    // each newly seen press unless cleared that edge. With filtering, a seen level must
    // persist for DEB consecutive edges before it counts.
    logic [6:0] m_req;
    logic [6:0] h1, h2, h3;
    logic [6:0] m_rise;
`ifdef CALL_DEBOUNCE_EN
    logic [6:0] flt, flt_d;
    int         run [7];
`endif

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_req = '0; h1 = '0; h2 = '0; h3 = '0;
`ifdef CALL_DEBOUNCE_EN
            flt = '0; flt_d = '0;
            for (int i = 0; i < 7; i++) run[i] = 0;
`endif
        end else begin
`ifdef CALL_DEBOUNCE_EN
            m_rise = flt & ~flt_d;
            flt_d  = flt;
            for (int i = 0; i < 7; i++) begin
                if (h2[i] != flt[i]) begin
                    run[i]++;
                    if (run[i] == DEB) begin
                        flt[i] = h2[i];
                        run[i] = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
`else
            m_rise = h2 & ~h3;
`endif
            m_req = (m_req | m_rise) & ~bus.clr;
            h3 = h2; h2 = h1; h1 = bus.btn_raw;
        end
    end

    always @(negedge clk) begin
        chk("req_vs_model", 32'(bus.req), 32'(m_req));
        chk("req_any_vs_model", 32'(bus.req_any), 32'(m_req != 0));
        chk("req_cnt_vs_model", 32'(bus.req_cnt), 32'($countones(m_req)));
    end

    task automatic lit(input string name, input logic [6:0] exp_req, input int exp_cnt);
        chk({name, "_req"}, 32'(bus.req), 32'(exp_req));
        chk({name, "_cnt"}, 32'(bus.req_cnt), 32'(exp_cnt));
        chk({name, "_model"}, 32'(m_req), 32'(exp_req));
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic settle();
        bus.btn_raw = '0;
        bus.clr     = 7'h7F;
        cycles(LAT + 4);
        bus.clr = '0;
        cycles(1);
    endtask

    int lat_cnt;

    initial begin
        rst_n       = 1'b0;
        bus.btn_raw = '0;
        bus.clr     = '0;
        cycles(3);
        chk("reset_req", 32'(bus.req), 32'h0);
        chk("reset_any", 32'(bus.req_any), 32'h0);
        chk("reset_cnt", 32'(bus.req_cnt), 32'h0);
        rst_n = 1'b1;
        cycles(2);

        // Press, clear while held, release and re-press.
        bus.btn_raw[0] = 1'b1;
        cycles(LAT);
        lit("t1_not_yet", 7'h00, 0);
        cycles(1);
        lit("t1_latched", 7'h01, 1);
        chk("t1_any", 32'(bus.req_any), 32'h1);
        bus.clr[0] = 1'b1;
        cycles(1);
        bus.clr[0] = 1'b0;
        lit("t1_cleared", 7'h00, 0);
        cycles(LAT + 5);
        lit("t1_held_no_relatch", 7'h00, 0);
        bus.btn_raw[0] = 1'b0;
        cycles(LAT + 3);
        bus.btn_raw[0] = 1'b1;
        cycles(LAT + 1);
        lit("t1_repress", 7'h01, 1);

        // Clear coinciding with a rise drops that press; other channels unaffected.
        settle();
        bus.btn_raw[5] = 1'b1;
        bus.btn_raw[6] = 1'b1;
        cycles(LAT);
        bus.clr[5] = 1'b1;
        cycles(1);
        bus.clr[5] = 1'b0;
        lit("t2_clr_beats_rise", 7'h40, 1);
        cycles(3);
        lit("t2_stays", 7'h40, 1);

        // All buttons at once, then a partial clear.
        settle();
        bus.btn_raw = 7'h7F;
        cycles(LAT + 1);
        lit("t3_all", 7'h7F, 7);
        bus.clr = 7'h05;
        cycles(1);
        bus.clr = '0;
        lit("t3_partial_clr", 7'h7A, 5);

`ifdef CALL_DEBOUNCE_EN
        // Bouncing contact shorter than the filter window never latches.
        settle();
        for (int c = 0; c < 40; c++) begin
            bus.btn_raw[2] = ((c / 3) % 2) == 0;
            cycles(1);
            chk("t4_bounce_ignored", 32'(bus.req[2]), 32'h0);
        end
        bus.btn_raw[2] = 1'b0;
        cycles(DEB + 4);
`endif
        // Latency: req appears LAT edges after the sampling edge.
        settle();
        bus.btn_raw[2] = 1'b1;
        lat_cnt = 0;
        while (bus.req[2] !== 1'b1 && lat_cnt < LAT + 20) begin
            cycles(1);
            lat_cnt++;
        end
        chk("t4_latency", 32'(lat_cnt), 32'(LAT + 1));

        // Asynchronous reset drops pending requests; a held button re-latches afterwards.
        settle();
        bus.btn_raw = 7'h11;
        cycles(LAT + 1);
        lit("t5_pending", 7'h11, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_req", 32'(bus.req), 32'h0);
        chk("t5_async_cnt", 32'(bus.req_cnt), 32'h0);
        bus.btn_raw = 7'h10;
        @(negedge clk);
        rst_n = 1'b1;
        cycles(LAT);
        lit("t5_not_yet", 7'h00, 0);
        cycles(1);
        lit("t5_relatch", 7'h10, 1);

        // Random presses, releases and clears against the model.
        settle();
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 7; i++) begin
                if ($urandom_range(0, 7) == 0) bus.btn_raw[i] = ~bus.btn_raw[i];
                bus.clr[i] = ($urandom_range(0, 9) == 0);
            end
            cycles(1);
        end
        bus.clr = '0;
        cycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
